uart_rx_fifo: RTL and testbench

Receive-side byte buffer placed directly downstream of the UART receiver, between the receiver's ready/valid byte output and the core's MMIO/UART register interface. The serial line cannot be stalled, so the block always accepts bytes from the receiver. It stores them in order and drops any byte that arrives while the buffer is full, recording the loss in a sticky overflow flag and a saturating drop counter. The read side is a first-word-fall-through ready/valid port.

---
 rtl/uart_rx_fifo_sync_fifo.sv | 60 ++++++
 rtl/uart_rx_fifo.sv | 76 +++++++
 tb/tb_uart_rx_fifo.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_fifo_sync_fifo.sv
// Generic first-word-fall-through FIFO with wrap-bit pointers and a flush input.
// Shared between the UART receive and transmit paths.
module sync_fifo #(
    parameter int  DEPTH = 16,
    parameter int  WIDTH = 8,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);
    localparam int IDX_W = CNT_W - 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [CNT_W-1:0] wr_ptr;
    logic [CNT_W-1:0] rd_ptr;
    logic             do_wr;
    logic             do_rd;

    function automatic logic [IDX_W-1:0] idx(input logic [CNT_W-1:0] ptr);
        return ptr[IDX_W-1:0];
    endfunction

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (idx(wr_ptr) == idx(rd_ptr)) && (wr_ptr[CNT_W-1] != rd_ptr[CNT_W-1]);
    assign count = wr_ptr - rd_ptr;

    // A read in the same cycle frees the slot that a write into a full FIFO needs.
    assign do_rd = rd_en & ~empty & ~flush;
    assign do_wr = wr_en & (~full | do_rd) & ~flush;

    assign rd_data = mem[idx(rd_ptr)];

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[idx(wr_ptr)] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + CNT_W'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + CNT_W'(1);
            end
        end
    end
endmodule

// File: rtl/uart_rx_fifo.sv
// Receive byte buffer behind the UART receiver: never stalls the line, drops
// bytes when full and records the loss in a sticky flag and saturating counter.
module uart_rx_fifo #(
    parameter int  DEPTH = 16,
    parameter int  WIDTH = 8,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] count,
    output logic             overflow,
    output logic [7:0]       drop_count,
    input  logic             overflow_clr,
    input  logic             flush
);
    logic push;
    logic pop;
    logic drop;
    logic full;
    logic empty;

    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign out_valid = ~empty;

    // A flushed byte is simply lost, not accounted as a drop.
    assign drop = push & full & ~pop & ~flush;

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush   (flush),
        .wr_en   (push),
        .wr_data (in_data),
        .rd_en   (out_ready),
        .rd_data (out_data),
        .full    (full),
        .empty   (empty),
        .count   (count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready <= 1'b0;
        end else begin
            in_ready <= 1'b1;
        end
    end

    // A drop in the same cycle as a clear leaves exactly that one drop recorded.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow   <= 1'b0;
            drop_count <= 8'd0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (overflow_clr) begin
                drop_count <= 8'd1;
            end else if (drop_count != 8'hFF) begin
                drop_count <= drop_count + 8'd1;
            end
        end else if (overflow_clr) begin
            overflow   <= 1'b0;
            drop_count <= 8'd0;
        end
    end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: a negedge scoreboard tracks every byte
// accepted and popped, while per-scenario tasks check the headline values.
module tb_uart_rx_fifo;
    localparam int DEPTH = 16;
    localparam int WIDTH = 8;
    localparam int CNT_W = 5;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic [CNT_W-1:0] count;
    logic             overflow;
    logic [7:0]       drop_count;
    logic             overflow_clr;
    logic             flush;

    int total = 0;
    int bad = 0;

    logic [7:0] exp_q[$];
    logic       m_ready = 1'b0;
    logic       m_ovf = 1'b0;
    logic [7:0] m_drops = 8'd0;
    bit         mon_on = 1'b0;
    int         n_popped = 0;
    logic [7:0] last_out = 8'd0;

    uart_rx_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .count        (count),
        .overflow     (overflow),
        .drop_count   (drop_count),
        .overflow_clr (overflow_clr),
        .flush        (flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    // Mid-cycle: compare DUT state against the model, then advance the model by the upcoming edge.
    always @(negedge clk) begin
        logic       exp_v;
        logic [4:0] exp_cnt;
        logic       pop_m;
        logic       req_m;
        logic       drop_m;
        if (mon_on) begin
            exp_v   = (exp_q.size() != 0);
            exp_cnt = 5'(exp_q.size());
            total++;
            if (out_valid !== exp_v) begin
                bad++;
                $display("[TB] FAIL mon_out_valid got=%0b want=%0b", out_valid, exp_v);
            end
            total++;
            if (count !== exp_cnt) begin
                bad++;
                $display("[TB] FAIL mon_count got=%0d want=%0d", count, exp_cnt);
            end
            total++;
            if (in_ready !== m_ready) begin
                bad++;
                $display("[TB] FAIL mon_in_ready got=%0b want=%0b", in_ready, m_ready);
            end
            total++;
            if (overflow !== m_ovf) begin
                bad++;
                $display("[TB] FAIL mon_overflow got=%0b want=%0b", overflow, m_ovf);
            end
            total++;
            if (drop_count !== m_drops) begin
                bad++;
                $display("[TB] FAIL mon_drop_count got=%0d want=%0d", drop_count, m_drops);
            end
            if (exp_v) begin
                total++;
                if (out_data !== exp_q[0]) begin
                    bad++;
                    $display("[TB] FAIL mon_out_data got=%02h want=%02h", out_data, exp_q[0]);
                end
            end

            if (rst) begin
                exp_q.delete();
                m_ready = 1'b0;
                m_ovf   = 1'b0;
                m_drops = 8'd0;
            end else begin
                pop_m  = 1'b0;
                drop_m = 1'b0;
                req_m  = in_valid & m_ready;
                if (flush) begin
                    exp_q.delete();
                end else begin
                    pop_m = exp_v & out_ready;
                    if (req_m) begin
                        if (exp_q.size() < DEPTH || pop_m) begin
                            exp_q.push_back(in_data);
                        end else begin
                            drop_m = 1'b1;
                        end
                    end
                    if (pop_m) begin
                        last_out = exp_q.pop_front();
                        n_popped++;
                    end
                end
                if (drop_m) begin
                    m_ovf = 1'b1;
                    if (overflow_clr) begin
                        m_drops = 8'd1;
                    end else if (m_drops != 8'hFF) begin
                        m_drops = m_drops + 8'd1;
                    end
                end else if (overflow_clr) begin
                    m_ovf   = 1'b0;
                    m_drops = 8'd0;
                end
                m_ready = 1'b1;
            end
        end
    end

    task automatic tick(input logic v, input logic [7:0] d, input logic r);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        mon_on = 1'b1;
        total++;
        if ({in_ready, out_valid, count, overflow, drop_count} !== 16'd0) begin
            bad++;
            $display("[TB] FAIL reset_values got=%b want=0", {in_ready, out_valid, count, overflow, drop_count});
        end
        rst = 1'b0;
        tick(1'b0, 8'h00, 1'b0);
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("[TB] FAIL reset_release_in_ready got=%0b want=1", in_ready);
        end
    endtask

    task automatic test_basic_order();
        tick(1'b1, 8'h41, 1'b0);
        tick(1'b1, 8'h42, 1'b0);
        tick(1'b1, 8'h43, 1'b0);
        total++;
        if (count !== 5'd3 || out_data !== 8'h41) begin
            bad++;
            $display("[TB] FAIL basic_fill got count=%0d data=%02h want count=3 data=41", count, out_data);
        end
        for (int i = 0; i < 3; i++) tick(1'b0, 8'h00, 1'b1);
        total++;
        if (out_valid !== 1'b0 || count !== 5'd0 || last_out !== 8'h43) begin
            bad++;
            $display("[TB] FAIL basic_drain got valid=%0b count=%0d last=%02h want 0 0 43", out_valid, count, last_out);
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 16; i++) tick(1'b1, 8'(i), 1'b0);
        tick(1'b1, 8'hAA, 1'b0);
        tick(1'b1, 8'hBB, 1'b0);
        total++;
        if (count !== 5'd16 || overflow !== 1'b1 || drop_count !== 8'd2) begin
            bad++;
            $display("[TB] FAIL overflow_state got count=%0d ovf=%0b drops=%0d want 16 1 2", count, overflow, drop_count);
        end
        for (int i = 0; i < 16; i++) tick(1'b0, 8'h00, 1'b1);
        total++;
        if (last_out !== 8'h0F || count !== 5'd0) begin
            bad++;
            $display("[TB] FAIL overflow_drain got last=%02h count=%0d want 0f 0", last_out, count);
        end
        overflow_clr = 1'b1;
        tick(1'b0, 8'h00, 1'b0);
        overflow_clr = 1'b0;
        total++;
        if (overflow !== 1'b0 || drop_count !== 8'd0) begin
            bad++;
            $display("[TB] FAIL overflow_clear got ovf=%0b drops=%0d want 0 0", overflow, drop_count);
        end
    endtask

    task automatic test_full_push_pop();
        for (int i = 0; i < 16; i++) tick(1'b1, 8'(i), 1'b0);
        tick(1'b1, 8'h55, 1'b1);
        total++;
        if (count !== 5'd16 || overflow !== 1'b0 || out_data !== 8'h01 || last_out !== 8'h00) begin
            bad++;
            $display("[TB] FAIL full_push_pop got count=%0d ovf=%0b head=%02h popped=%02h want 16 0 01 00",
                     count, overflow, out_data, last_out);
        end
        for (int i = 0; i < 16; i++) tick(1'b0, 8'h00, 1'b1);
        total++;
        if (last_out !== 8'h55 || out_valid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL full_push_pop_last got last=%02h valid=%0b want 55 0", last_out, out_valid);
        end
    endtask

    task automatic test_wrap_around();
        int start;
        start = n_popped;
        for (int i = 0; i < 40; i++) begin
            tick(1'b1, 8'(i), 1'(i % 2));
            if (i % 4 == 3) tick(1'b0, 8'h00, 1'b1);
        end
        for (int i = 0; i < 12; i++) tick(1'b0, 8'h00, 1'b1);
        total++;
        if (n_popped - start != 40 || last_out !== 8'h27 || overflow !== 1'b0 || drop_count !== 8'd0) begin
            bad++;
            $display("[TB] FAIL wrap_stream got popped=%0d last=%02h ovf=%0b drops=%0d want 40 27 0 0",
                     n_popped - start, last_out, overflow, drop_count);
        end
    endtask

    task automatic test_flush_clear();
        for (int i = 0; i < 19; i++) tick(1'b1, 8'(8'h60 + i), 1'b0);
        for (int i = 0; i < 11; i++) tick(1'b0, 8'h00, 1'b1);
        total++;
        if (count !== 5'd5 || overflow !== 1'b1 || drop_count !== 8'd3) begin
            bad++;
            $display("[TB] FAIL flush_setup got count=%0d ovf=%0b drops=%0d want 5 1 3", count, overflow, drop_count);
        end
        flush = 1'b1;
        tick(1'b1, 8'h77, 1'b0);
        flush = 1'b0;
        total++;
        if (count !== 5'd0 || out_valid !== 1'b0 || overflow !== 1'b1 || drop_count !== 8'd3) begin
            bad++;
            $display("[TB] FAIL flush_state got count=%0d valid=%0b ovf=%0b drops=%0d want 0 0 1 3",
                     count, out_valid, overflow, drop_count);
        end
        for (int i = 0; i < 16; i++) tick(1'b1, 8'(i), 1'b0);
        overflow_clr = 1'b1;
        tick(1'b1, 8'hEE, 1'b0);
        overflow_clr = 1'b0;
        total++;
        if (overflow !== 1'b1 || drop_count !== 8'd1) begin
            bad++;
            $display("[TB] FAIL clear_vs_drop got ovf=%0b drops=%0d want 1 1", overflow, drop_count);
        end
    endtask

    task automatic test_saturation_reset();
        for (int i = 0; i < 300; i++) tick(1'b1, 8'(i), 1'b0);
        total++;
        if (drop_count !== 8'd255 || overflow !== 1'b1 || count !== 5'd16) begin
            bad++;
            $display("[TB] FAIL saturation got drops=%0d ovf=%0b count=%0d want 255 1 16", drop_count, overflow, count);
        end
        rst = 1'b1;
        tick(1'b0, 8'h00, 1'b0);
        rst = 1'b0;
        total++;
        if ({in_ready, out_valid, count, overflow, drop_count} !== 16'd0) begin
            bad++;
            $display("[TB] FAIL midrun_reset got=%b want=0", {in_ready, out_valid, count, overflow, drop_count});
        end
        tick(1'b0, 8'h00, 1'b0);
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_rerelease got ready=%0b valid=%0b want 1 0", in_ready, out_valid);
        end
    endtask

    initial begin
        rst          = 1'b1;
        in_valid     = 1'b0;
        in_data      = 8'h00;
        out_ready    = 1'b0;
        overflow_clr = 1'b0;
        flush        = 1'b0;
        $display("[TB] starting uart_rx_fifo bench");
        test_reset();
        test_basic_order();
        test_overflow();
        test_full_push_pop();
        test_wrap_around();
        test_flush_clear();
        test_saturation_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
